branch_unit: RTL

- Execute-stage neighbour directly downstream of the ALU; consumes its zero/less/compare outputs.
- Holds the architectural flags register written by CMP/TEST and resolves conditional and unconditional branches.
- Drives a registered redirect (take_branch, branch_pc) to fetch and a multi-cycle flush to the front-end pipeline registers.
- Contains an IDLE/FLUSH state machine plus stall handling.

---
 rtl/branch_unit_pkg.sv | 23 ++
 rtl/branch_unit_cond_eval.sv | 35 +++
 rtl/branch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/branch_unit_pkg.sv
// Shared constants for the branch unit: condition codes, default widths and FSM encoding.
package branch_unit_pkg;

    localparam int BU_ADDR_WIDTH = 16;
    localparam int BU_COND_BITS  = 4;

    localparam int COND_NEVER = 0;
    localparam int COND_JMP   = 1;
    localparam int COND_JE    = 2;
    localparam int COND_JNE   = 3;
    localparam int COND_JL    = 4;
    localparam int COND_JLE   = 5;
    localparam int COND_JG    = 6;
    localparam int COND_JGE   = 7;
    localparam int COND_BEQ   = 8;
    localparam int COND_BNE   = 9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bu_state_t;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Combinational condition evaluator: maps a condition code and flags to {taken, illegal}.
module branch_cond_eval
    import branch_unit_pkg::*;
#(
    parameter int COND_BITS = BU_COND_BITS
) (
    input  logic [COND_BITS-1:0] cond_i,
    input  logic                 zero_i,
    input  logic                 less_i,
    input  logic                 greater_i,
    input  logic                 compare_i,
    output logic                 taken_o,
    output logic                 illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (cond_i)
            COND_BITS'(COND_NEVER): taken_o = 1'b0;
            COND_BITS'(COND_JMP):   taken_o = 1'b1;
            COND_BITS'(COND_JE):    taken_o = zero_i;
            COND_BITS'(COND_JNE):   taken_o = !zero_i;
            COND_BITS'(COND_JL):    taken_o = less_i;
            COND_BITS'(COND_JLE):   taken_o = less_i | zero_i;
            COND_BITS'(COND_JG):    taken_o = greater_i;
            COND_BITS'(COND_JGE):   taken_o = greater_i | zero_i;
            // Register-compare branches ignore the flags entirely.
            COND_BITS'(COND_BEQ):   taken_o = compare_i;
            COND_BITS'(COND_BNE):   taken_o = !compare_i;
            default:                illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Flags register, branch resolution and redirect/flush FSM for the execute stage.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = BU_ADDR_WIDTH,
    parameter int FLUSH_CYCLES = 2,
    parameter int COND_BITS    = BU_COND_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flag_wr,
    input  logic                  zero_in,
    input  logic                  less_in,
    input  logic                  compare_in,
    input  logic                  branch_valid,
    input  logic [COND_BITS-1:0]  branch_cond,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  flag_zero,
    output logic                  flag_less,
    output logic                  flag_greater,
    output logic                  take_branch,
    output logic [ADDR_WIDTH-1:0] branch_pc,
    output logic                  flush,
    output logic                  illegal_cond,
    output bu_state_t             dbg_state
);

    bu_state_t             state_q;
    logic [2:0]            cnt_q;
    logic                  z_q, l_q, g_q;
    logic                  take_q, flush_q, illegal_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    logic fused;
    logic eff_z, eff_l, eff_g;
    logic cond_taken, cond_illegal;

    // A compare fused with a branch evaluates on the ALU outputs directly.
    assign fused = flag_wr && branch_valid;
    assign eff_z = fused ? zero_in : z_q;
    assign eff_l = fused ? less_in : l_q;
    assign eff_g = fused ? (!less_in && !zero_in) : g_q;

    branch_cond_eval #(
        .COND_BITS (COND_BITS)
    ) u_eval (
        .cond_i    (branch_cond),
        .zero_i    (eff_z),
        .less_i    (eff_l),
        .greater_i (eff_g),
        .compare_i (compare_in),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            z_q       <= 1'b0;
            l_q       <= 1'b0;
            g_q       <= 1'b0;
            take_q    <= 1'b0;
            flush_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
        end else if (stall) begin
            // Pulses drop so a redirect is never repeated; everything else holds.
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flag_wr) begin
                        z_q <= zero_in;
                        l_q <= less_in;
                        g_q <= !less_in && !zero_in;
                    end
                    if (branch_valid) begin
                        illegal_q <= cond_illegal;
                        if (cond_taken) begin
                            state_q <= ST_FLUSH;
                            cnt_q   <= 3'(FLUSH_CYCLES);
                            take_q  <= 1'b1;
                            pc_q    <= branch_target;
                            flush_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 3'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 3'd0;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign flag_zero    = z_q;
    assign flag_less    = l_q;
    assign flag_greater = g_q;
    assign take_branch  = take_q;
    assign branch_pc    = pc_q;
    assign flush        = flush_q;
    assign illegal_cond = illegal_q;
    assign dbg_state    = state_q;

endmodule
